// File: rtl/riscv_pkg.sv
// Shared RV32I constants for the core: instruction encodings, opcodes and ALU selects.
package riscv_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [6:0] {
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_BRANCH = 7'b1100011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_OP_IMM = 7'b0010011,
    OPC_OP     = 7'b0110011
  } opcode_e;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR,  ALU_AND
  } alu_op_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_id_hold.sv
// IF/ID stall capture: keeps the instruction word the ROM showed before a stall
// began, since the ROM moves on to pc_f while decode is frozen.
module if_id_hold
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  input  logic            capture,
  input  logic            clear,
  input  logic [XLEN-1:0] din,
  output logic [XLEN-1:0] dout,
  output logic            hold_valid
);

  logic [XLEN-1:0] hold_d, hold_q;
  logic            hold_valid_d, hold_valid_q;

  always_comb begin
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    if (clear) begin
      hold_valid_d = 1'b0;
    end else if (capture) begin
      hold_d       = din;
      hold_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q       <= NOP_INSTR;
      hold_valid_q <= 1'b0;
    end else begin
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
    end
  end

  assign dout       = hold_q;
  assign hold_valid = hold_valid_q;

endmodule

// File: rtl/instruction_fetch.sv
// IF stage plus IF/ID register: PC sequencing, redirect flush and stall hold
// in front of a 1-cycle synchronous instruction ROM.
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        pc_id,
  output logic [31:0]        pc_plus4_id,
  output logic [31:0]        instr_id,
  output logic               valid_id,
  output logic               misalign_err
);

  logic [31:0] pc_f_d, pc_f_q;
  logic [31:0] pc_id_d, pc_id_q;
  logic [31:0] pc_plus4_id_d, pc_plus4_id_q;
  logic        valid_id_d, valid_id_q;
  logic        misalign_err_d, misalign_err_q;
  logic        hold_capture, hold_clear, hold_valid;
  logic [31:0] hold_word;
  logic        unused_redirect_lsb;

  // Bit 0 of a JALR target is architecturally discarded.
  assign unused_redirect_lsb = redirect_pc[0];

  always_comb begin
    pc_f_d         = pc_f_q;
    pc_id_d        = pc_id_q;
    pc_plus4_id_d  = pc_plus4_id_q;
    valid_id_d     = valid_id_q;
    misalign_err_d = misalign_err_q;
    if (redirect) begin
      pc_f_d     = word_align(redirect_pc);
      valid_id_d = 1'b0;
      if (redirect_pc[1]) misalign_err_d = 1'b1;
    end else if (!stall) begin
      pc_f_d        = pc_f_q + 32'd4;
      pc_id_d       = pc_f_q;
      pc_plus4_id_d = pc_f_q + 32'd4;
      valid_id_d    = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q         <= RESET_PC;
      pc_id_q        <= 32'h0000_0000;
      pc_plus4_id_q  <= 32'h0000_0004;
      valid_id_q     <= 1'b0;
      misalign_err_q <= 1'b0;
    end else begin
      pc_f_q         <= pc_f_d;
      pc_id_q        <= pc_id_d;
      pc_plus4_id_q  <= pc_plus4_id_d;
      valid_id_q     <= valid_id_d;
      misalign_err_q <= misalign_err_d;
    end
  end

  // Only the first stalled cycle captures; the ROM already shows pc_f after that.
  assign hold_capture = stall && !redirect && !hold_valid;
  assign hold_clear   = !stall || redirect;

  if_id_hold u_hold (
    .clk        (clk),
    .reset      (reset),
    .capture    (hold_capture),
    .clear      (hold_clear),
    .din        (imem_rdata),
    .dout       (hold_word),
    .hold_valid (hold_valid)
  );

  assign imem_addr    = pc_f_q[IMEM_AW+1:2];
  assign pc_id        = pc_id_q;
  assign pc_plus4_id  = pc_plus4_id_q;
  assign valid_id     = valid_id_q;
  assign misalign_err = misalign_err_q;
  assign instr_id     = !valid_id_q ? NOP_INSTR : (hold_valid ? hold_word : imem_rdata);

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a ROM model holding ROM[i] = i + 0x100.
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset, stall, redirect;
  logic [31:0] redirect_pc;
  logic [9:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc_id, pc_plus4_id, instr_id;
  logic        valid_id, misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) imem_rdata <= 32'h100 + {22'b0, imem_addr};

  instruction_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .pc_id        (pc_id),
    .pc_plus4_id  (pc_plus4_id),
    .instr_id     (instr_id),
    .valid_id     (valid_id),
    .misalign_err (misalign_err)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_id(input string tag, input logic [31:0] pc, input logic [31:0] ins);
    check({tag, ".valid"}, {31'b0, valid_id}, 32'd1);
    check({tag, ".pc"}, pc_id, pc);
    check({tag, ".pc4"}, pc_plus4_id, pc + 32'd4);
    check({tag, ".instr"}, instr_id, ins);
  endtask

  task automatic expect_bubble(input string tag);
    check({tag, ".valid"}, {31'b0, valid_id}, 32'd0);
    check({tag, ".instr"}, instr_id, NOP);
  endtask

  task automatic do_redirect(input logic [31:0] target);
    redirect    = 1'b1;
    redirect_pc = target;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    tick(); tick();
    reset = 1'b0;
    expect_bubble("rst");
    check("rst.pc", pc_id, 32'h0);
    check("rst.pc4", pc_plus4_id, 32'h4);
    check("rst.mis", {31'b0, misalign_err}, 32'd0);

    tick(); expect_id("seq0", 32'h0, 32'h100);
    tick(); expect_id("seq1", 32'h4, 32'h101);
    tick(); expect_id("seq2", 32'h8, 32'h102);

    do_redirect(32'h40);
    expect_bubble("redir.bubble");
    tick(); expect_id("redir.tgt", 32'h40, 32'h110);
    tick(); expect_id("redir.next", 32'h44, 32'h111);

    do_redirect(32'h0);
    tick(); tick(); tick(); tick();
    expect_id("pre_stall", 32'hC, 32'h103);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_id($sformatf("stall%0d", i), 32'hC, 32'h103);
    end
    stall = 1'b0;
    #1 expect_id("release", 32'hC, 32'h103);
    tick(); expect_id("post_stall0", 32'h10, 32'h104);
    tick(); expect_id("post_stall1", 32'h14, 32'h105);

    stall = 1'b1;
    tick(); expect_id("sr.stall", 32'h14, 32'h105);
    do_redirect(32'h80);
    expect_bubble("sr.bubble");
    stall = 1'b0;
    tick(); expect_id("sr.tgt", 32'h80, 32'h120);

    do_redirect(32'h21);
    check("mis.lsb0", {31'b0, misalign_err}, 32'd0);
    tick(); expect_id("mis.lsb", 32'h20, 32'h108);
    check("mis.lsb1", {31'b0, misalign_err}, 32'd0);
    do_redirect(32'h22);
    check("mis.set0", {31'b0, misalign_err}, 32'd1);
    tick(); expect_id("mis.bit1", 32'h20, 32'h108);
    tick(); check("mis.sticky0", {31'b0, misalign_err}, 32'd1);
    do_redirect(32'h21);
    tick(); check("mis.sticky1", {31'b0, misalign_err}, 32'd1);

    do_redirect(32'hFFFF_FFFC);
    tick(); expect_id("wrap.top", 32'hFFFF_FFFC, 32'h4FF);
    check("wrap.pc4", pc_plus4_id, 32'h0);
    tick(); expect_id("wrap.zero", 32'h0, 32'h100);

    do_redirect(32'h30);
    tick(); expect_id("rs.pre", 32'h30, 32'h10C);
    stall = 1'b1;
    tick(); expect_id("rs.stall", 32'h30, 32'h10C);
    reset = 1'b1;
    tick();
    reset = 1'b0; stall = 1'b0;
    expect_bubble("rs.rst");
    check("rs.pc", pc_id, 32'h0);
    check("rs.pc4", pc_plus4_id, 32'h4);
    check("rs.mis", {31'b0, misalign_err}, 32'd0);
    tick(); expect_id("rs.first", 32'h0, 32'h100);
    tick(); expect_id("rs.second", 32'h4, 32'h101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
